// File: rtl/axi_alu_pipe.sv
// Valid/ready ALU stage (add/sub/mul/xor) with a show-ahead result FIFO; AXI_ALU_SAT_EN makes add/sub saturate.
// Latency: 1 EXEC cycle for add/sub/xor, MUL_CYCLES for mul, from the accept edge to the result push.
// Backpressure: a FIFO slot is reserved at accept, so a full FIFO stalls in_ready and never blocks a push.

module axi_alu_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [DW-1:0]   push_dat,
  input  logic            pop_rdy,
  output logic [DW-1:0]   head_dat,
  output logic            head_vld,
  output logic [CNTW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rptr];
  assign pop      = head_vld && pop_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      // Simultaneous push and pop leaves the count alone.
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module axi_alu_pipe #(
  parameter int W          = 4,
  parameter int MUL_CYCLES = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*W+1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W+1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);
  localparam int CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int CNTW = $clog2(OUT_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EXEC = 1'b1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic [0:0]      state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [1:0]      op_q;
  logic [CW-1:0]   cnt;
  logic [CNTW-1:0] fifo_count;
  logic            accept;
  logic            push;
  logic [W:0]      sum;
  logic [W:0]      diff;
  logic [2*W-1:0]  prod;
  logic [2*W-1:0]  res;

  assign in_ready = (state == ST_IDLE) && (fifo_count < CNTW'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_EXEC);
  assign push     = (state == ST_EXEC) && ((op_q != OP_MUL) || (cnt == '0));

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

  always_comb begin
    res = '0;
    case (op_q)
`ifdef AXI_ALU_SAT_EN
      // Carry out means overflow; borrow out means a < b.
      OP_ADD: res = {{W{1'b0}}, (sum[W] ? {W{1'b1}} : sum[W-1:0])};
      OP_SUB: res = {{W{1'b0}}, (diff[W] ? {W{1'b0}} : diff[W-1:0])};
`else
      OP_ADD: res = {{(W-1){1'b0}}, sum};
      OP_SUB: res = {{(W-1){1'b0}}, diff};
`endif
      OP_MUL: res = prod;
      OP_XOR: res = {{W{1'b0}}, a_q ^ b_q};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= in_data[W-1:0];
            b_q   <= in_data[2*W-1:W];
            op_q  <= in_data[2*W+1:2*W];
            cnt   <= CW'(MUL_CYCLES - 1);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (push) state <= ST_IDLE;
          else      cnt   <= cnt - CW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_alu_fifo #(
    .DW   (2*W+2),
    .DEPTH(OUT_DEPTH),
    .CNTW (CNTW)
  ) u_res_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_dat({op_q, res}),
    .pop_rdy (out_ready),
    .head_dat(out_data),
    .head_vld(out_valid),
    .count   (fifo_count)
  );
endmodule
